// File: rtl/cocochip_peak_detector.sv
// cocochip_peak_detector: settles after a MUX channel change, then reports the peak of each fixed-size sample window
// Optional build macro PEAK_TO_PEAK_EN: also track the window minimum and report max - min instead of the raw maximum.
module cocochip_peak_detector #(
    parameter int SETTLE_CYCLES  = 64,
    parameter int WINDOW_SAMPLES = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] channel_sel,
    input  logic [7:0] sample_in,
    input  logic       sample_valid,
    output logic [7:0] adc_data,
    output logic       adc_data_valid,
    output logic       adc_clip
);
    localparam int CW = $clog2(WINDOW_SAMPLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, ACQUIRE, REPORT} state_t;

    state_t        state_q;
    logic [1:0]    chan_q;
    logic [SW-1:0] settle_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [7:0]    peak_q;
    logic [7:0]    peak_d;
    logic          clip_q;
    logic          clip_d;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          aclip_q;
    logic [7:0]    result;
    logic          first;
    logic          last;
    logic          halt;
    logic          changed;
`ifdef PEAK_TO_PEAK_EN
    logic [7:0]    min_q;
    logic [7:0]    min_d;
`endif

    assign adc_data       = data_q;
    assign adc_data_valid = valid_q;
    assign adc_clip       = aclip_q;

    // Merge the incoming sample into the running window statistics; the first sample of a window always loads.
    always_comb begin
        first   = count_q == '0;
        peak_d  = (first || sample_in > peak_q) ? sample_in : peak_q;
        clip_d  = (first ? 1'b0 : clip_q) | (sample_in == 8'hFF);
        count_d = count_q + 1'b1;
        last    = count_d == CW'(WINDOW_SAMPLES);
        halt    = !enable || channel_sel == 2'b11;
        changed = channel_sel != chan_q;
`ifdef PEAK_TO_PEAK_EN
        min_d   = (first || sample_in < min_q) ? sample_in : min_q;
        result  = peak_d - min_d;
`else
        result  = peak_d;
`endif
    end

    // Control FSM; the result registers load on the edge that accepts the last window sample, so the strobe is the REPORT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            chan_q   <= 2'b00;
            settle_q <= '0;
            count_q  <= '0;
            peak_q   <= 8'd0;
            clip_q   <= 1'b0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            aclip_q  <= 1'b0;
`ifdef PEAK_TO_PEAK_EN
            min_q    <= 8'd0;
`endif
        end else begin
            chan_q  <= channel_sel;
            valid_q <= 1'b0;
            if (state_q == IDLE) begin
                if (!halt) begin
                    state_q  <= SETTLE;
                    settle_q <= SW'(SETTLE_CYCLES);
                end
            end else if (halt) begin
                state_q <= IDLE;
            end else if (changed) begin
                state_q  <= SETTLE;
                settle_q <= SW'(SETTLE_CYCLES);
            end else if (state_q == SETTLE) begin
                settle_q <= settle_q - 1'b1;
                if (settle_q == SW'(1)) begin
                    state_q <= ACQUIRE;
                    count_q <= '0;
                    peak_q  <= 8'd0;
                    clip_q  <= 1'b0;
`ifdef PEAK_TO_PEAK_EN
                    min_q   <= 8'd0;
`endif
                end
            end else if (sample_valid) begin
`ifdef PEAK_TO_PEAK_EN
                min_q <= last ? 8'd0 : min_d;
`endif
                if (last) begin
                    state_q <= REPORT;
                    count_q <= '0;
                    peak_q  <= 8'd0;
                    clip_q  <= 1'b0;
                    data_q  <= result;
                    aclip_q <= clip_d;
                    valid_q <= 1'b1;
                end else begin
                    state_q <= ACQUIRE;
                    count_q <= count_d;
                    peak_q  <= peak_d;
                    clip_q  <= clip_d;
                end
            end else begin
                state_q <= ACQUIRE;
            end
        end
    end
endmodule

// File: tb/tb_cocochip_peak_detector.sv
// tb_cocochip_peak_detector: directed windows with a scoreboard queue checked by a separate strobe monitor
module tb_cocochip_peak_detector;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] channel_sel = 2'b00;
    logic [7:0] sample_in = 8'd0;
    logic       sample_valid = 1'b0;
    logic [7:0] adc_data;
    logic       adc_data_valid;
    logic       adc_clip;

    int         nvec = 0;
    int         nerr = 0;
    int         cyc = 0;
    logic [7:0] q_data[$];
    logic       q_clip[$];
    int         q_time[$];
    logic [7:0] last_data = 8'd0;
    logic       last_clip = 1'b0;

    cocochip_peak_detector #(.SETTLE_CYCLES(4), .WINDOW_SAMPLES(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .channel_sel(channel_sel),
        .sample_in(sample_in), .sample_valid(sample_valid),
        .adc_data(adc_data), .adc_data_valid(adc_data_valid), .adc_clip(adc_clip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [1:0] ch, input logic v, input logic [7:0] d);
        @(posedge clk);
        #1;
        enable = en;
        channel_sel = ch;
        sample_valid = v;
        sample_in = d;
    endtask

    task automatic tick(input logic v, input logic [7:0] d);
        drive(enable, channel_sel, v, d);
    endtask

    task automatic settle(input logic v, input logic [7:0] d);
        repeat (4) tick(v, d);
    endtask

    // Sends the first n samples of v (first sample in the top byte); a full window queues its expected report.
    task automatic win(input logic [63:0] v, input int n);
        logic [7:0] mx, mn, s, e;
        logic       cl;
        mx = 8'd0;
        mn = 8'hFF;
        cl = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s = v[63-8*i -: 8];
            mx = (s > mx) ? s : mx;
            mn = (s < mn) ? s : mn;
            cl = cl | (s == 8'hFF);
        end
`ifdef PEAK_TO_PEAK_EN
        e = mx - mn;
`else
        e = mx;
`endif
        for (int i = 0; i < n; i++) begin
            tick(1'b1, v[63-8*i -: 8]);
            if (i == 7) begin
                q_data.push_back(e);
                q_clip.push_back(cl);
                q_time.push_back(cyc + 1);
                last_data = e;
                last_clip = cl;
            end
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard in value and timing.
    initial forever begin
        @(negedge clk);
        if (adc_data_valid) begin
            if (q_data.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_strobe: got strobe at cycle %0d with data %0d, expected none", cyc, adc_data);
            end else begin
                chk("adc_data", adc_data, q_data.pop_front());
                chk("adc_clip", adc_clip, q_clip.pop_front());
                chk("strobe_cycle", cyc, q_time.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data", adc_data, 0);
        chk("reset_valid", adc_data_valid, 0);
        chk("reset_clip", adc_clip, 0);
        chk("reset_state", int'(dut.state_q), 0);
        reset = 1'b0;
        drive(1'b1, 2'b00, 1'b0, 8'd0);
        settle(1'b0, 8'd0);
        win({8'd10, 8'd50, 8'd30, 8'd200, 8'd7, 8'd9, 8'd100, 8'd1}, 8);
        tick(1'b0, 8'd0);
        drive(1'b0, 2'b00, 1'b0, 8'd0);
        drive(1'b1, 2'b00, 1'b1, 8'd250);
        settle(1'b1, 8'd250);
        win({8'd3, 8'd90, 8'd12, 8'd0, 8'd45, 8'd89, 8'd60, 8'd2}, 8);
        tick(1'b0, 8'd0);
        win({8'd240, 8'd240, 8'd240, 8'd240, 8'd240, 8'd240, 8'd240, 8'd240}, 5);
        drive(1'b1, 2'b01, 1'b0, 8'd0);
        settle(1'b0, 8'd0);
        win({8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18}, 8);
        tick(1'b0, 8'd0);
        win({8'd230, 8'd230, 8'd230, 8'd230, 8'd230, 8'd230, 8'd230, 8'd230}, 7);
        drive(1'b1, 2'b10, 1'b1, 8'd250);
        settle(1'b0, 8'd0);
        win({8'd1, 8'd255, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8}, 8);
        tick(1'b0, 8'd0);
        win({8'd40, 8'd39, 8'd38, 8'd37, 8'd36, 8'd35, 8'd34, 8'd33}, 8);
        tick(1'b0, 8'd0);
        win({8'd100, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170}, 8);
        win({8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2}, 8);
        tick(1'b0, 8'd0);
        tick(1'b0, 8'd0);
        win({8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99}, 3);
        drive(1'b0, 2'b10, 1'b0, 8'd0);
        drive(1'b0, 2'b10, 1'b0, 8'd0);
        chk("disable_state", int'(dut.state_q), 0);
        chk("disable_hold_data", adc_data, last_data);
        chk("disable_hold_clip", adc_clip, last_clip);
        drive(1'b1, 2'b10, 1'b0, 8'd0);
        settle(1'b0, 8'd0);
        win({8'd60, 8'd61, 8'd62, 8'd63, 8'd64, 8'd65, 8'd66, 8'd67}, 6);
        drive(1'b1, 2'b11, 1'b1, 8'd250);
        drive(1'b1, 2'b11, 1'b1, 8'd250);
        chk("invalid_chan_state", int'(dut.state_q), 0);
        chk("invalid_chan_hold_data", adc_data, last_data);
        drive(1'b1, 2'b00, 1'b0, 8'd0);
        settle(1'b0, 8'd0);
        win({8'd70, 8'd71, 8'd72, 8'd73, 8'd74, 8'd75, 8'd76, 8'd77}, 4);
        @(posedge clk);
        #1;
        enable = 1'b0;
        sample_valid = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_data", adc_data, 0);
        chk("midreset_clip", adc_clip, 0);
        chk("midreset_state", int'(dut.state_q), 0);
        drive(1'b1, 2'b00, 1'b0, 8'd0);
        settle(1'b0, 8'd0);
        win({8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12}, 8);
        repeat (6) tick(1'b0, 8'd0);
        chk("pending_reports", q_data.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
